sprite_draw_scheduler: RTL
==========================

Name: sprite_draw_scheduler

Overview:
- Arbitrates rectangular sprite/fill draw requests from up to NUM_REQ requesters (background, target, hitbox notes, menu, song titles) onto the single ROM-address bus and vga_adapter pixel-write port.
- For each granted job it scans the rectangle, issues sprite ROM addresses, and compensates for synchronous ROM latency.
- Applies clipping, colour-key transparency and solid fill, then drives registered plot/x/y/colour.
- Sits between the game-state FSMs (requesters) and the vga_adapter; the sprite-ROM output mux is external and selected by rom_sel.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ROM_LAT, 1, sprite ROM read latency in cycles (address registered here → q valid ROM_LAT cycles later)
SCR_W, 320, screen width; pixels with x >= SCR_W are not plotted
SCR_H, 240, screen height; pixels with y >= SCR_H are not plotted

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester draw request, level
req_x  in  NUM_REQ*9  x offset, requester i at [9i+8:9i]
req_y  in  NUM_REQ*8  y offset
req_wm1  in  NUM_REQ*9  width-1
req_hm1  in  NUM_REQ*8  height-1
req_sel  in  NUM_REQ*4  sprite ROM select code
req_fill  in  NUM_REQ  1 = solid fill with req_colour, ROM ignored
req_keyen  in  NUM_REQ  1 = colour-key transparency enabled
req_colour  in  NUM_REQ*12  fill colour (fill mode) or key colour (key mode)
grant  out  NUM_REQ  one-hot, high for the whole job
done  out  NUM_REQ  one-cycle pulse to the granted requester at job end
busy  out  1  high whenever state != IDLE
rom_address  out  17  sprite ROM address, registered
rom_sel  out  4  latched req_sel of the current job
rom_data  in  12  muxed sprite ROM q
vga_x  out  9  registered pixel x
vga_y  out  8  registered pixel y
vga_colour  out  12  registered pixel colour
vga_plot  out  1  registered write enable

Behaviour:
- Reset (async, active-high): state=IDLE; grant, done, busy, vga_plot = 0; rom_address, vga_x, vga_y, vga_colour, rom_sel = 0; RR pointer = NUM_REQ-1; pipeline valid bits cleared. Reset mid-job abandons the job; no done pulse.
- States:
  - IDLE → LOAD when any req bit is high. Round-robin search starts at pointer+1, wrapping. The winner's parameters are latched, grant[winner]=1, and pointer=winner.
  - LOAD (1 cycle): cx=cy=0, addr=0.
  - SCAN, one pixel per cycle: rom_address<=addr; stage-0 tag = {x = xoff+cx mod 512, y = yoff+cy mod 256, valid=1}. Then addr+=1. If cx==wm1, cx=0 and cy+=1; otherwise cx+=1. Once cx==wm1 && cy==hm1 has been issued → DRAIN.
  - DRAIN: exactly ROM_LAT+1 cycles to flush the pipeline → DONE.
  - DONE (1 cycle): done[winner]=1, grant cleared → IDLE. The next grant is possible at the following edge.
- Pixel pipeline: the tag is delayed ROM_LAT cycles to align with rom_data, then registered to the vga_* outputs. A pixel reaches vga_* ROM_LAT+1 cycles after its address edge; the first pixel of a job appears on vga_* at cycle LOAD+ROM_LAT+2.
- vga_plot = valid && x<SCR_W && y<SCR_H && !(keyen && !fill && rom_data==key).
- vga_colour = fill ? req_colour : rom_data.
- vga_x/vga_y update even when plot=0.
- Job length: (wm1+1)*(hm1+1) SCAN cycles. wm1=hm1=0 is a 1-pixel job. Maximum 320x240 = 76800 addresses, which fits in 17 bits.
- Requests are sampled only in IDLE. Deasserting req during a job does not abort it. Changing a requester's parameters during its job has no effect. A requester holding req high across done is granted again only after the other active requesters have been served (round-robin fairness).
- grant and done are never high for more than one requester at a time. busy=1 in LOAD/SCAN/DRAIN/DONE.

Test Plan:
- Reset then req=0001, x=10, y=20, wm1=1, hm1=1, fill=1, colour=0x884 → grant[0] from the edge after req; 4 plots at (10,20),(11,20),(10,21),(11,21), all colour 0x884; done[0] one cycle after the last plot pipeline flush; busy low after.
- req0 keyen=1, key=0xFFF, wm1=3, hm1=0, ROM model returns 0x0F0,0xFFF,0x123,0xFFF for addr 0..3 → plot pattern 1,0,1,0 at x=xoff..xoff+3; rom_address 0..3 on consecutive cycles.
- req=1111 held constantly → grants in order 0,1,2,3,0; never two grant bits set; each done precedes the next grant.
- Clip: x=318, y=239, wm1=3, hm1=1 → plot only at (318,239) and (319,239); the other 6 pixels have plot=0; done still after 8 SCAN cycles.
- Assert reset in SCAN of a 16x16 job → grant, busy, vga_plot = 0 immediately (asynchronous), no done; after release, a fresh req0 job restarts at address 0.
- ROM_LAT=2 build, 1x1 job → vga_plot high exactly 3 cycles after the rom_address=0 edge; DRAIN lasts 3 cycles.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// -----------------------------------------------------------------------------
// sprite_draw_scheduler
//
// Purpose:
//    Shares the sprite ROM address bus and the vga_adapter pixel-write port
//    between up to NUM_REQ rectangle draw requesters. Requesters are served
//    round-robin. Each granted job is scanned one pixel per cycle in raster
//    order. Every pixel carries a tag through a delay line that matches the
//    synchronous ROM latency. At the output, screen clipping, colour-key
//    transparency and solid fill are applied before the registered VGA write.
//
// Ports:
//    CLOCK_50, reset        clock, asynchronous active-high reset
//    req[i]                 level draw request from requester i
//    req_x/y/wm1/hm1[i]     rectangle origin and size-1 (packed per requester)
//    req_sel[i]             sprite ROM select code, reflected on rom_sel
//    req_fill[i]            1 = solid fill with req_colour, ROM ignored
//    req_keyen[i]           1 = pixels equal to req_colour are transparent
//    req_colour[i]          fill colour or key colour
//    grant                  one-hot, high for the whole job
//    done                   one-cycle pulse to the served requester at job end
//    busy                   scheduler not idle
//    rom_address, rom_sel   registered ROM address and latched ROM select
//    rom_data               muxed sprite ROM output (ROM_LAT cycles latency)
//    vga_x/y/colour/plot    registered pixel write to the vga_adapter
// -----------------------------------------------------------------------------
module sprite_draw_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ROM_LAT = 1,
   parameter int SCR_W   = 320,
   parameter int SCR_H   = 240
) (
   input  logic                  CLOCK_50,
   input  logic                  reset,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*9-1:0]  req_x,
   input  logic [NUM_REQ*8-1:0]  req_y,
   input  logic [NUM_REQ*9-1:0]  req_wm1,
   input  logic [NUM_REQ*8-1:0]  req_hm1,
   input  logic [NUM_REQ*4-1:0]  req_sel,
   input  logic [NUM_REQ-1:0]    req_fill,
   input  logic [NUM_REQ-1:0]    req_keyen,
   input  logic [NUM_REQ*12-1:0] req_colour,
   output logic [NUM_REQ-1:0]    grant,
   output logic [NUM_REQ-1:0]    done,
   output logic                  busy,
   output logic [16:0]           rom_address,
   output logic [3:0]            rom_sel,
   input  logic [11:0]           rom_data,
   output logic [8:0]            vga_x,
   output logic [7:0]            vga_y,
   output logic [11:0]           vga_colour,
   output logic                  vga_plot
);

   localparam int IW = $clog2(NUM_REQ);
   localparam int DW = $clog2(ROM_LAT + 2);
   // Widened by one bit so that a screen limit of 512 (or 256) is still valid.
   localparam logic [9:0] SCR_W_L = 10'(SCR_W);
   localparam logic [8:0] SCR_H_L = 9'(SCR_H);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_DRAIN, S_DONE} state_t;

   // Parameters of the job in progress, captured at grant time so the
   // requester may change its inputs freely while it is being served.
   typedef struct packed {
      logic [8:0]  x;
      logic [7:0]  y;
      logic [8:0]  wm1;
      logic [7:0]  hm1;
      logic [3:0]  sel;
      logic        fill;
      logic        keyen;
      logic [11:0] colour;
   } job_t;

   state_t               state_q, state_d;
   logic [IW-1:0]        ptr_q, ptr_d;
   job_t                 job_q, job_d;
   logic [8:0]           cx_q, cx_d;
   logic [7:0]           cy_q, cy_d;
   logic [16:0]          addr_q, addr_d;
   logic [DW-1:0]        drain_q, drain_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic [NUM_REQ-1:0]   done_q, done_d;
   logic [16:0]          rom_address_q, rom_address_d;

   // ---------------------------------------------------------------------------
   // Round-robin search: the first active request after the last winner.
   // ---------------------------------------------------------------------------
   logic          any_req;
   logic [IW-1:0] rr_win;

   always_comb begin : rr_search
      logic [IW-1:0] idx;
      any_req = 1'b0;
      rr_win  = ptr_q;
      idx     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = IW'((int'(ptr_q) + k) % NUM_REQ);
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            rr_win  = idx;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Control FSM: next state and registered-output next values.
   // ---------------------------------------------------------------------------
   always_comb begin : fsm_next
      // NOTE: every signal gets a default before the case so no path leaves
      // one unassigned; that is what keeps this block free of latches.
      state_d       = state_q;
      ptr_d         = ptr_q;
      job_d         = job_q;
      cx_d          = cx_q;
      cy_d          = cy_q;
      addr_d        = addr_q;
      drain_d       = drain_q;
      grant_d       = grant_q;
      done_d        = '0;
      rom_address_d = rom_address_q;

      case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d      = S_LOAD;
               ptr_d        = rr_win;
               grant_d      = NUM_REQ'(1) << rr_win;
               job_d.x      = req_x[int'(rr_win)*9 +: 9];
               job_d.y      = req_y[int'(rr_win)*8 +: 8];
               job_d.wm1    = req_wm1[int'(rr_win)*9 +: 9];
               job_d.hm1    = req_hm1[int'(rr_win)*8 +: 8];
               job_d.sel    = req_sel[int'(rr_win)*4 +: 4];
               job_d.fill   = req_fill[rr_win];
               job_d.keyen  = req_keyen[rr_win];
               job_d.colour = req_colour[int'(rr_win)*12 +: 12];
            end
         end

         S_LOAD: begin
            cx_d    = '0;
            cy_d    = '0;
            addr_d  = '0;
            state_d = S_SCAN;
         end

         S_SCAN: begin
            rom_address_d = addr_q;
            addr_d        = addr_q + 17'd1;
            if (cx_q == job_q.wm1) begin
               cx_d = '0;
               if (cy_q == job_q.hm1) begin
                  state_d = S_DRAIN;
                  drain_d = '0;
               end else begin
                  cy_d = cy_q + 8'd1;
               end
            end else begin
               cx_d = cx_q + 9'd1;
            end
         end

         // ROM_LAT+1 cycles: the last address still has to cross the ROM and
         // the output register before the job can be reported complete.
         S_DRAIN: begin
            if (drain_q == DW'(ROM_LAT)) begin
               state_d = S_DONE;
            end else begin
               drain_d = drain_q + DW'(1);
            end
         end

         S_DONE: begin
            done_d  = grant_q;
            grant_d = '0;
            state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the values of the previous cycle regardless of order.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         ptr_q         <= IW'(NUM_REQ - 1);
         job_q         <= '0;
         cx_q          <= '0;
         cy_q          <= '0;
         addr_q        <= '0;
         drain_q       <= '0;
         grant_q       <= '0;
         done_q        <= '0;
         rom_address_q <= '0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         job_q         <= job_d;
         cx_q          <= cx_d;
         cy_q          <= cy_d;
         addr_q        <= addr_d;
         drain_q       <= drain_d;
         grant_q       <= grant_d;
         done_q        <= done_d;
         rom_address_q <= rom_address_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Pixel tag pipeline. Stage 0 is loaded on the same edge as rom_address;
   // stage ROM_LAT lines up with the rom_data for that address.
   // ---------------------------------------------------------------------------
   logic [ROM_LAT:0] vld_q;
   logic [8:0]       tx_q [0:ROM_LAT];
   logic [7:0]       ty_q [0:ROM_LAT];

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
      end else begin
         vld_q <= {vld_q[ROM_LAT-1:0], (state_q == S_SCAN)};
      end
   end

   // NOTE: the coordinate tags carry no reset; a tag is only ever consumed
   // together with its valid bit, which is reset above.
   always_ff @(posedge CLOCK_50) begin
      tx_q[0] <= job_q.x + cx_q;   // wraps modulo 512
      ty_q[0] <= job_q.y + cy_q;   // wraps modulo 256
      for (int i = 1; i <= ROM_LAT; i++) begin
         tx_q[i] <= tx_q[i-1];
         ty_q[i] <= ty_q[i-1];
      end
   end

   // ---------------------------------------------------------------------------
   // Output stage: clip, colour key, fill select, then register.
   // ---------------------------------------------------------------------------
   logic in_screen, key_hit, plot_d;

   assign in_screen = ({1'b0, tx_q[ROM_LAT]} < SCR_W_L) &&
                      ({1'b0, ty_q[ROM_LAT]} < SCR_H_L);
   assign key_hit   = job_q.keyen && !job_q.fill && (rom_data == job_q.colour);
   assign plot_d    = vld_q[ROM_LAT] && in_screen && !key_hit;

   logic [8:0]  vga_x_q;
   logic [7:0]  vga_y_q;
   logic [11:0] vga_colour_q;
   logic        vga_plot_q;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
      end else begin
         vga_plot_q <= plot_d;
         // Coordinates follow every scanned pixel, plotted or not.
         if (vld_q[ROM_LAT]) begin
            vga_x_q      <= tx_q[ROM_LAT];
            vga_y_q      <= ty_q[ROM_LAT];
            vga_colour_q <= job_q.fill ? job_q.colour : rom_data;
         end
      end
   end

   assign grant       = grant_q;
   assign done        = done_q;
   assign busy        = (state_q != S_IDLE);
   assign rom_address = rom_address_q;
   assign rom_sel     = job_q.sel;
   assign vga_x       = vga_x_q;
   assign vga_y       = vga_y_q;
   assign vga_colour  = vga_colour_q;
   assign vga_plot    = vga_plot_q;

endmodule
